elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
- Parametrised successor to the current 4-floor elevator core: N-floor car controller with a latched call register, SCAN (collector) direction policy, a timed floor-to-floor travel counter, a timed door, and an emergency-stop freeze.
- Sits between the debounced/synchronised reset and request inputs and the display/LED driver in the top level.
- Consumes only clean synchronous signals; emits floor, direction and status for display.

Parameters:
- FLOORS, 8, number of floors (>=2); floors numbered 0..FLOORS-1.
- FLOOR_TICKS, 50_000_000, clk cycles to travel one floor (>=1).
- DOOR_TICKS, 100_000_000, clk cycles the door stays open (>=1).
- FW, $clog2(FLOORS), floor index width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  FLOORS  call request per floor; level, sampled every cycle, bit i = call to floor i.
- estop  in  1  emergency stop; level, freezes motion and door timer while high.
- cur_floor  out  FW  current car floor.
- dir_up  out  1  1 = travelling/preferring up, 0 = down.
- moving  out  1  high in MOVE state and estop low.
- door_open  out  1  high in DOOR state.
- pending  out  FLOORS  latched outstanding calls (LED mirror).

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0, tick counter=0. Reset mid-move or mid-door aborts immediately; takes priority over everything.
- Call latch: pending <= (pending | req) & ~clr. clr = onehot(cur_floor) in DOOR state, else 0. Decisions use eff = pending | req, so a call is acted on the same cycle it arrives. Calls are never cancelled except by servicing.
- ahead = any eff bit strictly above cur_floor if dir_up, else strictly below; behind = same for the opposite direction.
- States: IDLE, MOVE, DOOR. All outputs registered.
- IDLE:
  - eff[cur_floor] -> DOOR, counter=0.
  - else ahead -> MOVE, dir unchanged.
  - else behind -> MOVE, dir_up toggled.
  - else stay IDLE.
- MOVE: counter increments each cycle. At counter==FLOOR_TICKS-1: cur_floor +/-1 per dir_up, counter=0. If eff[new floor] -> DOOR, else stay MOVE. A request always exists further ahead because bits are cleared only in DOOR. cur_floor never leaves 0..FLOORS-1.
- DOOR: counter increments. req[cur_floor] during DOOR restarts counter=0 (door hold) and is not latched. At counter==DOOR_TICKS-1 -> IDLE, counter=0. IDLE re-decides next cycle, giving a 1-cycle IDLE gap.
- Latency:
  - req in IDLE at the current floor, edge t -> door_open=1 at t+1.
  - req elsewhere at t -> moving=1 at t+1; first floor change at t+1+FLOOR_TICKS.
  - Door open for exactly DOOR_TICKS cycles absent holds.
- estop high: state, counter, cur_floor and dir_up frozen; moving=0; door_open keeps its value; call latch still updates, except clr is suppressed. Release resumes with the remaining ticks.
- Simultaneous events:
  - Reset beats estop; estop beats all transitions.
  - An arrival floor's call arriving in the same cycle as the arrival stops the car there.
  - Calls above and below while IDLE with no preference: continue in the current dir_up.

Test Plan (FLOORS=8, FLOOR_TICKS=4, DOOR_TICKS=3):
- Reset -> cur_floor=0, dir_up=1, moving=0, door_open=0, pending=8'h00; hold reset mid-move at floor 3 -> floor 0 on next edge.
- At floor 0 idle, 1-cycle req[0] -> door_open high exactly 3 cycles, pending[0] never visible after door opens, then IDLE.
- 1-cycle req[5] at floor 0 -> moving next cycle; cur_floor 1,2,3,4,5 every 4 cycles; door opens at floor 5; pending=8'h00 afterwards.
- Car moving up past 3 toward 6, pulse req[1] and req[5] -> stops 5 then 6, dir_up->0, travels down to 1 and stops; stop order 5,6,1.
- estop asserted 2 cycles into a floor leg for 10 cycles -> cur_floor unchanged, moving=0; after release floor changes 2 cycles later.
- During DOOR at floor 2, re-pulse req[2] on the last door cycle -> door stays open 3 more cycles.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator car controller: latched calls, SCAN direction policy,
// timed floor-to-floor travel, timed door with hold, emergency-stop freeze.
module elevator_ctrl_n #(
  parameter  int FLOORS      = 8,
  parameter  int FLOOR_TICKS = 50_000_000,
  parameter  int DOOR_TICKS  = 100_000_000,
  localparam int FW          = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] req_i,
  input  logic              estop_i,
  output logic [FW-1:0]     cur_floor_o,
  output logic              dir_up_o,
  output logic              moving_o,
  output logic              door_open_o,
  output logic [FLOORS-1:0] pending_o
);

  localparam int MAXT = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] FLOOR_LAST = CW'(FLOOR_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST  = CW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] pend_q, pend_d;
  logic              moving_q, moving_d;
  logic              door_q, door_d;

  logic [FLOORS-1:0] eff_s;
  logic [FLOORS-1:0] clr_s;
  logic              above_s, below_s, ahead_s, behind_s;
  logic [FW-1:0]     next_floor_s;

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] idx);
    onehot = {{(FLOORS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      pend_q   <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      moving_q <= moving_d;
      door_q   <= door_d;
    end
  end

  // Call visibility relative to the car; a fresh request counts in its own cycle
  always_comb begin
    eff_s   = pend_q | req_i;
    above_s = 1'b0;
    below_s = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      above_s = above_s | (eff_s[i] & (i > int'(floor_q)));
      below_s = below_s | (eff_s[i] & (i < int'(floor_q)));
    end
    ahead_s  = dir_q ? above_s : below_s;
    behind_s = dir_q ? below_s : above_s;
    if (dir_q) begin
      next_floor_s = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FW'(1);
    end else begin
      next_floor_s = (floor_q == '0) ? floor_q : floor_q - FW'(1);
    end
  end

  // Next-state logic; estop holds every piece of motion state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    if (!estop_i) begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (eff_s[floor_q]) begin
            state_d = S_DOOR;
          end else if (ahead_s) begin
            state_d = S_MOVE;
          end else if (behind_s) begin
            state_d = S_MOVE;
            dir_d   = ~dir_q;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MOVE: begin
          if (cnt_q == FLOOR_LAST) begin
            cnt_d   = '0;
            floor_d = next_floor_s;
            state_d = eff_s[next_floor_s] ? S_DOOR : S_MOVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DOOR: begin
          if (req_i[floor_q]) begin
            cnt_d = '0;
          end else if (cnt_q == DOOR_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output and call-latch next values; the serviced floor clears as the door opens
  always_comb begin
    moving_d = (state_d == S_MOVE) && !estop_i;
    door_d   = (state_d == S_DOOR);
    if ((state_d == S_DOOR) && !estop_i) begin
      clr_s = onehot(floor_d);
    end else begin
      clr_s = '0;
    end
    pend_d = eff_s & ~clr_s;
  end

  assign cur_floor_o = floor_q;
  assign dir_up_o    = dir_q;
  assign moving_o    = moving_q;
  assign door_open_o = door_q;
  assign pending_o   = pend_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n: vector table, directed corner
// sequences, and randomized traffic against a countdown-based reference model.
module tb_elevator_ctrl_n;

  localparam int NF = 8;
  localparam int FT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       estop;
  logic [7:0] req;
  logic [2:0] cur_floor;
  logic       dir_up, moving, door_open;
  logic [7:0] pending;

  int n_err = 0;
  int n_chk = 0;
  bit mchk  = 1'b0;

  elevator_ctrl_n #(.FLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .estop_i    (estop),
    .cur_floor_o(cur_floor),
    .dir_up_o   (dir_up),
    .moving_o   (moving),
    .door_open_o(door_open),
    .pending_o  (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // inputs change right after a falling edge; outputs are read there too
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_floor(input int f, input int budget);
    int k;
    k = 0;
    while (int'(cur_floor) != f && k < budget) begin
      step();
      k++;
    end
    check("wait_floor", 32'(cur_floor), 32'(f));
  endtask

  // ---------------- reference model: remaining-ticks countdown ----------------
  typedef enum {PARKED, TRAVEL, DWELL} mmode_t;
  mmode_t     m_mode;
  int         m_floor, m_left, e;
  bit         m_up, m_moving, m_door, m_above, m_below;
  logic [7:0] m_pend;

  always @(posedge clk) begin
    e = int'(m_pend | req);
    if (!rst_n) begin
      m_mode = PARKED; m_floor = 0; m_up = 1'b1; m_left = 0;
      m_pend = 8'h00; m_moving = 1'b0; m_door = 1'b0;
    end else if (estop) begin
      m_pend   = e[7:0];
      m_moving = 1'b0;
    end else begin
      m_above = (e >> (m_floor + 1)) != 0;
      m_below = (e & ((1 << m_floor) - 1)) != 0;
      case (m_mode)
        PARKED: begin
          if (((e >> m_floor) & 1) != 0) begin
            m_mode = DWELL; m_left = DT;
          end else if (m_up ? m_above : m_below) begin
            m_mode = TRAVEL; m_left = FT;
          end else if (m_up ? m_below : m_above) begin
            m_mode = TRAVEL; m_left = FT; m_up = !m_up;
          end
        end
        TRAVEL: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_floor = m_up ? m_floor + 1 : m_floor - 1;
            if (((e >> m_floor) & 1) != 0) begin
              m_mode = DWELL; m_left = DT;
            end else begin
              m_left = FT;
            end
          end
        end
        default: begin
          if (req[m_floor]) begin
            m_left = DT;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = PARKED;
          end
        end
      endcase
      if (m_mode == DWELL) e = e & ~(1 << m_floor);
      m_pend   = e[7:0];
      m_moving = (m_mode == TRAVEL);
      m_door   = (m_mode == DWELL);
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      check("model", {18'd0, cur_floor, dir_up, moving, door_open, pending},
            {18'd0, m_floor[2:0], m_up, m_moving, m_door, m_pend});
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [7:0] rq;
    logic       es;
    logic [2:0] fl;
    logic       up;
    logic       mv;
    logic       dr;
    logic [7:0] pd;
  } vec_t;

  vec_t tbl[15];
  int   stops[3];
  int   ns;
  bit   prev_door;
  bit   dir_at_last;
  int   r, idx;

  initial begin
    rst_n = 1'b0; req = 8'h00; estop = 1'b0;

    tbl[0]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h04, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[11] = '{1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[12] = '{1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[14] = '{1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 8'h00};

    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rst; req = tbl[i].rq; estop = tbl[i].es;
      step();
      if (i == 0) mchk = 1'b1;
      check($sformatf("vec%0d", i),
            {18'd0, cur_floor, dir_up, moving, door_open, pending},
            {18'd0, tbl[i].fl, tbl[i].up, tbl[i].mv, tbl[i].dr, tbl[i].pd});
    end
    req = 8'h00;

    // door hold: re-press floor 2 on the last open cycle
    step(); step();
    req = 8'h04; step(); req = 8'h00;
    check("hold_door0", 32'(door_open), 32'd1);
    check("hold_pend", 32'(pending), 32'h00);
    step(); check("hold_door1", 32'(door_open), 32'd1);
    step(); check("hold_door2", 32'(door_open), 32'd1);
    step(); check("hold_close", 32'(door_open), 32'd0);

    // single call to floor 5 from floor 0
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 8'h20; step(); req = 8'h00;
    check("go5_moving", 32'(moving), 32'd1);
    check("go5_floor0", 32'(cur_floor), 32'd0);
    for (int f = 1; f <= 5; f++) begin
      repeat (FT) step();
      check($sformatf("go5_floor%0d", f), 32'(cur_floor), 32'(f));
    end
    check("go5_door", 32'(door_open), 32'd1);
    check("go5_pend", 32'(pending), 32'h00);
    repeat (DT) step();
    check("go5_closed", 32'(door_open), 32'd0);

    // collector order: heading to 6, calls at 5 and 1 while passing 4
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 8'h40; step(); req = 8'h00;
    wait_floor(4, 100);
    req = 8'h22; step(); req = 8'h00;
    ns = 0; prev_door = door_open; dir_at_last = 1'b1;
    stops[0] = -1; stops[1] = -1; stops[2] = -1;
    for (int k = 0; k < 300 && ns < 3; k++) begin
      step();
      if (door_open && !prev_door) begin
        stops[ns] = int'(cur_floor);
        dir_at_last = dir_up;
        ns++;
      end
      prev_door = door_open;
    end
    check("scan_count", 32'(ns), 32'd3);
    check("scan_stop0", 32'(stops[0]), 32'd5);
    check("scan_stop1", 32'(stops[1]), 32'd6);
    check("scan_stop2", 32'(stops[2]), 32'd1);
    check("scan_dir", 32'(dir_at_last), 32'd0);
    repeat (DT) step();

    // reset mid-move near floor 3
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 8'h80; step(); req = 8'h00;
    wait_floor(3, 100);
    step(); step();
    rst_n = 1'b0; step();
    check("rst_floor", 32'(cur_floor), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_pend", 32'(pending), 32'h00);
    rst_n = 1'b1;

    // estop two cycles into the first leg, held for 10 cycles
    req = 8'h08; step(); req = 8'h00;
    step(); step();
    estop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req = (k == 4) ? 8'h40 : 8'h00;
      step();
      check("estop_moving", 32'(moving), 32'd0);
      check("estop_floor", 32'(cur_floor), 32'd0);
    end
    check("estop_pend", 32'(pending), 32'h48);
    estop = 1'b0; req = 8'h00;
    step();
    check("resume_floor0", 32'(cur_floor), 32'd0);
    check("resume_moving", 32'(moving), 32'd1);
    step();
    check("resume_floor1", 32'(cur_floor), 32'd1);

    // randomized traffic, checked against the model every cycle
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      r   = int'($urandom_range(0, 99));
      idx = int'($urandom_range(0, 7));
      req = (r < 12) ? (8'h01 << idx) : 8'h00;
      if (r == 0) req = 8'($urandom);
      if ($urandom_range(0, 39) == 0) estop = ~estop;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; estop = 1'b0; req = 8'h00;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
